// File: rtl/spm_ctrl_pkg.sv
// spm_ctrl_pkg: shared word width, scratchpad defaults, external-port FSM
// encodings and the address-window helper used by spm_ctrl.
package spm_ctrl_pkg;

    localparam int                    WORD_WIDTH    = 32;
    localparam int                    SPM_DEPTH_DEF = 4096;
    localparam logic [WORD_WIDTH-1:0] SPM_BASE_DEF  = 32'h0001_0000;

    // External port FSM: IDLE accepts a request, RSP presents the held response.
    typedef enum logic [0:0] {
        SPM_ST_IDLE = 1'b0,
        SPM_ST_RSP  = 1'b1
    } spm_state_e;

    // True when addr lies in the window at base spanning 2**idx_w words.
    // Only the bits above the word index are compared; addr[1:0] is ignored.
    function automatic logic spm_in_range(input logic [WORD_WIDTH-1:0] addr,
                                          input logic [WORD_WIDTH-1:0] base,
                                          input int                    idx_w);
        logic [WORD_WIDTH-1:0] diff;
        diff = addr ^ base;
        return (diff >> (idx_w + 2)) == '0;
    endfunction

endpackage

// File: rtl/spm_ram.sv
// spm_ram: single-port synchronous RAM with per-byte write enables and a
// registered, read-first output. Contents are not reset so the module can be
// replaced by a technology macro with the same behaviour.
module spm_ram
    import spm_ctrl_pkg::*;
#(
    parameter int DEPTH = SPM_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [AW-1:0]         addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Read-first access: the output register always sees the pre-write word.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spm_ctrl.sv
// spm_ctrl: data scratchpad controller. Core loads/stores own the array port
// with one-cycle read latency and are never stalled. The optional external
// (debug/DMA) port is built only when SIICPU_SPM_EXT_PORT_EN is defined;
// otherwise its outputs are tied to zero and the port list stays the same.
//
// External handshake rules: a request transfers on a cycle where
// ext_req_valid && ext_req_ready; a response transfers on a cycle where
// ext_rsp_valid && ext_rsp_ready. ext_req_* are sampled only on the request
// transfer cycle, and the response fields are held stable while
// ext_rsp_valid is high and ext_rsp_ready is low.
module spm_ctrl
    import spm_ctrl_pkg::*;
#(
    parameter int                    SPM_DEPTH = SPM_DEPTH_DEF,
    parameter logic [WORD_WIDTH-1:0] SPM_BASE  = SPM_BASE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_en,
    input  logic                  core_rd_en,
    input  logic                  core_we_en,
    input  logic [WORD_WIDTH-1:0] core_addr,
    input  logic [3:0]            core_byteena,
    input  logic [WORD_WIDTH-1:0] core_wr_data,
    output logic [WORD_WIDTH-1:0] core_rd_data,
    output logic                  core_addr_err,
    input  logic                  ext_req_valid,
    output logic                  ext_req_ready,
    input  logic                  ext_req_we,
    input  logic [WORD_WIDTH-1:0] ext_req_addr,
    input  logic [3:0]            ext_req_byteena,
    input  logic [WORD_WIDTH-1:0] ext_req_wdata,
    output logic                  ext_rsp_valid,
    input  logic                  ext_rsp_ready,
    output logic [WORD_WIDTH-1:0] ext_rsp_rdata,
    output logic                  ext_rsp_err
);

    localparam int IDX_W = $clog2(SPM_DEPTH);

    logic                  core_fire;
    logic                  core_in_range;
    logic                  ext_in_range;
    logic                  ext_hs;
    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [IDX_W-1:0]      ram_addr;
    logic [WORD_WIDTH-1:0] ram_wdata;
    logic [WORD_WIDTH-1:0] ram_rdata;

    assign core_fire     = core_en && (core_rd_en || core_we_en);
    assign core_in_range = spm_in_range(core_addr, SPM_BASE, IDX_W);
    assign ext_in_range  = spm_in_range(ext_req_addr, SPM_BASE, IDX_W);

    // Single array port: the core always wins; the external port only reaches
    // the array on its handshake cycle, which cannot coincide with a core access.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = core_addr[IDX_W+1:2];
        ram_wdata = core_wr_data;
        if (core_fire) begin
            ram_en = core_in_range;
            ram_we = core_we_en ? core_byteena : 4'b0000;
        end else if (ext_hs) begin
            ram_en    = ext_in_range;
            ram_we    = ext_req_we ? ext_req_byteena : 4'b0000;
            ram_addr  = ext_req_addr[IDX_W+1:2];
            ram_wdata = ext_req_wdata;
        end
    end

    spm_ram #(
        .DEPTH (SPM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Core return path: show the RAM output right after an in-range read,
    // otherwise the hold register, which captures whatever was last shown.
    logic                  rd_sel_q, rd_sel_d;
    logic [WORD_WIDTH-1:0] rd_hold_q, rd_hold_d;
    logic                  addr_err_q, addr_err_d;

    assign core_rd_data  = rd_sel_q ? ram_rdata : rd_hold_q;
    assign core_addr_err = addr_err_q;

    // Next-state for the core return path and the out-of-range flag.
    always_comb begin
        rd_sel_d   = 1'b0;
        rd_hold_d  = core_rd_data;
        addr_err_d = addr_err_q;
        if (core_fire) begin
            addr_err_d = !core_in_range;
            if (core_rd_en) begin
                rd_sel_d = core_in_range;
                if (!core_in_range) begin
                    rd_hold_d = '0;
                end
            end
        end
    end

    // Core return path registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel_q   <= 1'b0;
            rd_hold_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rd_sel_q   <= rd_sel_d;
            rd_hold_q  <= rd_hold_d;
            addr_err_q <= addr_err_d;
        end
    end

`ifdef SIICPU_SPM_EXT_PORT_EN
    spm_state_e            state_q, state_d;
    logic                  ext_sel_q, ext_sel_d;
    logic [WORD_WIDTH-1:0] ext_hold_q, ext_hold_d;
    logic                  ext_err_q, ext_err_d;

    // First RSP cycle after an in-range read shows the RAM output; after that
    // the hold register keeps the response stable against core traffic.
    assign ext_rsp_rdata = ext_sel_q ? ram_rdata : ext_hold_q;
    assign ext_rsp_err   = ext_err_q;

    // External FSM next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        ext_sel_d     = 1'b0;
        ext_hold_d    = ext_rsp_rdata;
        ext_err_d     = ext_err_q;
        ext_req_ready = 1'b0;
        ext_rsp_valid = 1'b0;
        ext_hs        = 1'b0;
        case (state_q)
            SPM_ST_IDLE: begin
                ext_req_ready = !core_fire;
                if (ext_req_valid && !core_fire) begin
                    ext_hs     = 1'b1;
                    state_d    = SPM_ST_RSP;
                    ext_sel_d  = ext_in_range && !ext_req_we;
                    ext_hold_d = '0;
                    ext_err_d  = !ext_in_range;
                end
            end
            SPM_ST_RSP: begin
                ext_rsp_valid = 1'b1;
                if (ext_rsp_ready) begin
                    state_d = SPM_ST_IDLE;
                end
            end
            default: state_d = SPM_ST_IDLE;
        endcase
    end

    // External FSM state and response hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SPM_ST_IDLE;
            ext_sel_q  <= 1'b0;
            ext_hold_q <= '0;
            ext_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ext_sel_q  <= ext_sel_d;
            ext_hold_q <= ext_hold_d;
            ext_err_q  <= ext_err_d;
        end
    end
`else
    logic unused_ext;

    assign ext_hs        = 1'b0;
    assign ext_req_ready = 1'b0;
    assign ext_rsp_valid = 1'b0;
    assign ext_rsp_rdata = '0;
    assign ext_rsp_err   = 1'b0;
    assign unused_ext    = ^{ext_req_valid, ext_rsp_ready, ext_in_range};
`endif

endmodule

// File: tb/tb_spm_ctrl.sv
// tb_spm_ctrl: self-checking bench for spm_ctrl. A word-addressed reference
// memory (associative array) plus expected-output variables model the
// scratchpad; external responses are tracked through expected queues.
// Ext-port scenarios are selected by SIICPU_SPM_EXT_PORT_EN.
`timescale 1ns/1ps
module tb_spm_ctrl;
    import spm_ctrl_pkg::*;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WIN   = 32;
`ifdef SIICPU_SPM_EXT_PORT_EN
    localparam bit          EXT   = 1'b1;
`else
    localparam bit          EXT   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_en, core_rd_en, core_we_en;
    logic [31:0] core_addr, core_wr_data, core_rd_data;
    logic [3:0]  core_byteena;
    logic        core_addr_err;
    logic        ext_req_valid, ext_req_ready, ext_req_we;
    logic [31:0] ext_req_addr, ext_req_wdata, ext_rsp_rdata;
    logic [3:0]  ext_req_byteena;
    logic        ext_rsp_valid, ext_rsp_ready, ext_rsp_err;

    spm_ctrl #(.SPM_DEPTH(DEPTH), .SPM_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .core_en(core_en), .core_rd_en(core_rd_en), .core_we_en(core_we_en),
        .core_addr(core_addr), .core_byteena(core_byteena), .core_wr_data(core_wr_data),
        .core_rd_data(core_rd_data), .core_addr_err(core_addr_err),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready), .ext_req_we(ext_req_we),
        .ext_req_addr(ext_req_addr), .ext_req_byteena(ext_req_byteena), .ext_req_wdata(ext_req_wdata),
        .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready),
        .ext_rsp_rdata(ext_rsp_rdata), .ext_rsp_err(ext_rsp_err)
    );

    // Clock
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mdl [int];
    logic [31:0] exp_rd  = '0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];

    // ---------------- reference model helpers ----------------
    function automatic bit in_spm(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_rd(input int idx);
        return mdl.exists(idx) ? mdl[idx] : 32'h0;
    endfunction

    // Apply the currently driven core access to the reference model.
    task automatic model_core();
        bit          inr;
        logic [31:0] old_w;
        if (!(core_en && (core_rd_en || core_we_en))) return;
        inr     = in_spm(core_addr);
        exp_err = !inr;
        old_w   = inr ? mdl_rd(widx(core_addr)) : 32'h0;
        if (core_rd_en) exp_rd = old_w;
        if (core_we_en && inr) mdl[widx(core_addr)] = merge(old_w, core_wr_data, core_byteena);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_set(input logic en, input logic rd, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] data);
        core_en = en; core_rd_en = rd; core_we_en = we;
        core_addr = addr; core_byteena = be; core_wr_data = data;
    endtask

    task automatic core_idle();
        core_set(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Drive one core access and advance one cycle with the model updated.
    task automatic core_op(input logic rd, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
        core_set(1'b1, rd, we, addr, be, data);
        model_core();
        tick();
        core_idle();
    endtask

    function automatic logic [31:0] rand_addr(input int oor_pct);
        int sel;
        sel = $urandom_range(0, 99);
        if (sel >= oor_pct) return BASE + 32'($urandom_range(0, WIN - 1) * 4) + 32'($urandom_range(0, 3));
        if (sel % 2 == 0)   return BASE - 32'($urandom_range(1, 16) * 4);
        return $urandom() | 32'h8000_0000;
    endfunction

    task automatic rand_core(input int fire_pct);
        int mode;
        mode = $urandom_range(0, 3);
        core_set($urandom_range(0, 99) < fire_pct, mode == 0 || mode == 2, mode == 1 || mode == 2,
                 rand_addr(15), 4'($urandom_range(0, 15)), $urandom());
    endtask

    task automatic ext_set(input logic valid, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
        ext_req_valid = valid; ext_req_we = we; ext_req_addr = addr;
        ext_req_byteena = be; ext_req_wdata = data;
    endtask

    // One external transaction with the core idle; returns the first response cycle.
    task automatic ext_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, output logic got_valid,
                            output logic [31:0] got_rdata, output logic got_err, output bit accepted);
        ext_set(1'b1, we, addr, be, data);
        accepted = 1'b0;
        for (int i = 0; i < 16 && !accepted; i++) begin
            #1;
            if (ext_req_ready) begin
                accepted = 1'b1;
                if (we && in_spm(addr)) mdl[widx(addr)] = merge(mdl_rd(widx(addr)), data, be);
            end
            tick();
        end
        ext_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        got_valid = ext_rsp_valid; got_rdata = ext_rsp_rdata; got_err = ext_rsp_err;
        ext_rsp_ready = 1'b1;
        tick();
        ext_rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        core_idle();
        ext_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        ext_rsp_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (3) tick();
        n_tests++; if (core_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", core_rd_data); end
        n_tests++; if (core_addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b want 0", core_addr_err); end
        n_tests++; if (ext_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", ext_rsp_valid); end
        n_tests++; if (ext_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", ext_rsp_rdata); end
        n_tests++; if (ext_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", ext_rsp_err); end
        n_tests++; if (ext_req_ready !== EXT) begin n_fail++; $display("FAIL reset_req_ready: got %b want %b", ext_req_ready, EXT); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_preload();
        for (int i = 0; i < WIN; i++) core_op(1'b0, 1'b1, BASE + 32'(i * 4), 4'hF, $urandom());
        core_op(1'b0, 1'b1, BASE + 32'((DEPTH - 1) * 4), 4'hF, $urandom());
    endtask

    task automatic test_core_directed();
        core_op(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
        core_op(1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_full_word: got %h want deadbeef", core_rd_data); end
        core_op(1'b1, 1'b0, BASE + 32'h13, 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_low_bits_ignored: got %h want deadbeef", core_rd_data); end
        core_op(1'b0, 1'b1, BASE + 32'h14, 4'hF, 32'h11223344);
        core_op(1'b0, 1'b1, BASE + 32'h14, 4'b0001, 32'h000000AA);
        core_op(1'b1, 1'b0, BASE + 32'h14, 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== 32'h112233AA) begin n_fail++; $display("FAIL byte_lane_store: got %h want 112233aa", core_rd_data); end
        core_op(1'b0, 1'b1, BASE + 32'h18, 4'hF, 32'h55667788);
        core_op(1'b1, 1'b1, BASE + 32'h18, 4'hF, 32'hCAFEF00D);
        n_tests++; if (core_rd_data !== 32'h55667788) begin n_fail++; $display("FAIL rd_we_old_word: got %h want 55667788", core_rd_data); end
        core_op(1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_we_write_wins: got %h want cafef00d", core_rd_data); end
        repeat (3) tick();
        n_tests++; if (core_rd_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_data_hold_idle: got %h want cafef00d", core_rd_data); end
        core_op(1'b0, 1'b1, BASE + 32'h1C, 4'hF, 32'h01020304);
        n_tests++; if (core_rd_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_data_hold_store: got %h want cafef00d", core_rd_data); end
    endtask

    task automatic test_core_oor();
        logic [31:0] alias_w;
        alias_w = mdl_rd(DEPTH - 1);
        core_op(1'b1, 1'b0, BASE - 32'd4, 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== 32'h0) begin n_fail++; $display("FAIL oor_load_data: got %h want 0", core_rd_data); end
        n_tests++; if (core_addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_load_err: got %b want 1", core_addr_err); end
        core_op(1'b0, 1'b1, BASE - 32'd4, 4'hF, 32'h0BADF00D);
        core_op(1'b1, 1'b0, BASE + 32'((DEPTH - 1) * 4), 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== alias_w) begin n_fail++; $display("FAIL oor_store_suppressed: got %h want %h", core_rd_data, alias_w); end
        n_tests++; if (core_addr_err !== 1'b0) begin n_fail++; $display("FAIL err_clears_in_range: got %b want 0", core_addr_err); end
        core_op(1'b1, 1'b0, BASE + 32'(DEPTH * 4), 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== 32'h0) begin n_fail++; $display("FAIL oor_above_data: got %h want 0", core_rd_data); end
        n_tests++; if (core_addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_above_err: got %b want 1", core_addr_err); end
    endtask

    task automatic test_core_random();
        logic exp_ready;
        for (int n = 0; n < 300; n++) begin
            rand_core(85);
            #1;
            exp_ready = EXT && !(core_en && (core_rd_en || core_we_en));
            n_tests++; if (ext_req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", n, ext_req_ready, exp_ready); end
            model_core();
            tick();
            n_tests++; if (core_rd_data !== exp_rd) begin n_fail++; $display("FAIL rnd_rd_data[%0d]: got %h want %h", n, core_rd_data, exp_rd); end
            n_tests++; if (core_addr_err !== exp_err) begin n_fail++; $display("FAIL rnd_addr_err[%0d]: got %b want %b", n, core_addr_err, exp_err); end
        end
        core_idle();
        tick();
    endtask

`ifdef SIICPU_SPM_EXT_PORT_EN
    task automatic test_ext_priority();
        logic [31:0] exp_w;
        core_set(1'b1, 1'b1, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
        ext_set(1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        #1;
        n_tests++; if (ext_req_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready_core_busy: got %b want 0", ext_req_ready); end
        model_core();
        tick();
        core_idle();
        #1;
        n_tests++; if (ext_req_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready_idle: got %b want 1", ext_req_ready); end
        exp_w = mdl_rd(4);
        tick();
        ext_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        n_tests++; if (ext_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL prio_rsp_valid: got %b want 1", ext_rsp_valid); end
        n_tests++; if (ext_rsp_rdata !== exp_w) begin n_fail++; $display("FAIL prio_rsp_rdata: got %h want %h", ext_rsp_rdata, exp_w); end
        for (int c = 0; c < 5; c++) begin
            if (c % 2 == 1) core_set(1'b1, 1'b1, 1'b0, BASE + 32'(($urandom_range(5, WIN - 1)) * 4), 4'h0, 32'h0);
            else core_idle();
            #1;
            n_tests++; if (ext_req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready[%0d]: got %b want 0", c, ext_req_ready); end
            model_core();
            tick();
            n_tests++; if (ext_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_rsp_valid[%0d]: got %b want 1", c, ext_rsp_valid); end
            n_tests++; if (ext_rsp_rdata !== exp_w) begin n_fail++; $display("FAIL hold_rsp_rdata[%0d]: got %h want %h", c, ext_rsp_rdata, exp_w); end
        end
        core_idle();
        ext_rsp_ready = 1'b1;
        tick();
        ext_rsp_ready = 1'b0;
        n_tests++; if (ext_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_done_valid: got %b want 0", ext_rsp_valid); end
    endtask

    task automatic test_ext_write_oor();
        logic        v, e;
        bit          ok;
        logic [31:0] d, w, exp_w, old0;
        w     = $urandom();
        exp_w = merge(mdl_rd(16), w, 4'b0110);
        ext_xfer(1'b1, BASE + 32'h40, 4'b0110, w, v, d, e, ok);
        n_tests++; if (!ok || v !== 1'b1) begin n_fail++; $display("FAIL ext_wr_rsp: accepted %0d valid %b want 1", ok, v); end
        n_tests++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL ext_wr_fields: got %h/%b want 0/0", d, e); end
        ext_xfer(1'b0, BASE + 32'h40, 4'h0, 32'h0, v, d, e, ok);
        n_tests++; if (!ok || d !== exp_w) begin n_fail++; $display("FAIL ext_rd_after_wr: got %h want %h", d, exp_w); end
        ext_xfer(1'b0, BASE - 32'd4, 4'h0, 32'h0, v, d, e, ok);
        n_tests++; if (!ok || d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL ext_oor_rd: got %h/%b want 0/1", d, e); end
        old0 = mdl_rd(0);
        ext_xfer(1'b1, BASE + 32'(DEPTH * 4), 4'hF, 32'hFFFF0000, v, d, e, ok);
        n_tests++; if (!ok || e !== 1'b1) begin n_fail++; $display("FAIL ext_oor_wr_err: got %b want 1", e); end
        core_op(1'b1, 1'b0, BASE, 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== old0) begin n_fail++; $display("FAIL ext_oor_wr_suppressed: got %h want %h", core_rd_data, old0); end
        core_op(1'b1, 1'b0, BASE + 32'h40, 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== exp_w) begin n_fail++; $display("FAIL core_sees_ext_wr: got %h want %h", core_rd_data, exp_w); end
    endtask

    task automatic test_ext_random();
        logic        we, inr, hs, fire;
        logic [31:0] addr, w;
        logic [3:0]  be;
        int          hold;
        for (int t = 0; t < 30; t++) begin
            we = 1'($urandom_range(0, 1)); addr = rand_addr(20); be = 4'($urandom_range(0, 15)); w = $urandom();
            inr = in_spm(addr);
            hs = 1'b0;
            for (int c = 0; c < 64 && !hs; c++) begin
                rand_core(50);
                ext_set(1'b1, we, addr, be, w);
                #1;
                fire = core_en && (core_rd_en || core_we_en);
                n_tests++; if (ext_req_ready !== !fire) begin n_fail++; $display("FAIL xr_req_ready[%0d]: got %b want %b", t, ext_req_ready, !fire); end
                hs = !fire;
                model_core();
                if (hs) begin
                    if (we) begin
                        exp_q.push_back(32'h0);
                        if (inr) mdl[widx(addr)] = merge(mdl_rd(widx(addr)), w, be);
                    end else begin
                        exp_q.push_back(inr ? mdl_rd(widx(addr)) : 32'h0);
                    end
                    exp_err_q.push_back(!inr);
                end
                tick();
                n_tests++; if (core_rd_data !== exp_rd) begin n_fail++; $display("FAIL xr_core_rd[%0d]: got %h want %h", t, core_rd_data, exp_rd); end
            end
            ext_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (!hs) begin
                n_tests++; n_fail++; $display("FAIL xr_handshake_timeout[%0d]: got no accept want accept", t);
                continue;
            end
            hold = $urandom_range(0, 3);
            for (int c = 0; c <= hold; c++) begin
                n_tests++; if (ext_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL xr_rsp_valid[%0d]: got %b want 1", t, ext_rsp_valid); end
                n_tests++; if (ext_rsp_rdata !== exp_q[0] || ext_rsp_err !== exp_err_q[0]) begin
                    n_fail++; $display("FAIL xr_rsp[%0d]: got %h/%b want %h/%b", t, ext_rsp_rdata, ext_rsp_err, exp_q[0], exp_err_q[0]);
                end
                rand_core(50);
                ext_rsp_ready = (c == hold);
                model_core();
                tick();
            end
            ext_rsp_ready = 1'b0;
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
            core_idle();
        end
        tick();
    endtask

    task automatic test_ext_reset_mid_rsp();
        ext_set(1'b1, 1'b1, BASE + 32'h44, 4'hF, 32'h13579BDF);
        tick();
        ext_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        mdl[17] = 32'h13579BDF;
        n_tests++; if (ext_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_before: got %b want 1", ext_rsp_valid); end
        repeat (2) tick();
        rst = 1'b1;
        #1;
        n_tests++; if (ext_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid_drop: got %b want 0", ext_rsp_valid); end
        exp_rd = '0; exp_err = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_tests++; if (ext_rsp_valid !== 1'b0 || ext_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_no_replay: got valid %b ready %b want 0 1", ext_rsp_valid, ext_req_ready);
        end
        core_op(1'b1, 1'b0, BASE + 32'h44, 4'h0, 32'h0);
        n_tests++; if (core_rd_data !== 32'h13579BDF) begin n_fail++; $display("FAIL rstmid_write_kept: got %h want 13579bdf", core_rd_data); end
    endtask
`else
    task automatic test_ext_tied_off();
        for (int c = 0; c < 20; c++) begin
            ext_set(1'b1, 1'b1, BASE + 32'($urandom_range(0, 7) * 4), 4'hF, $urandom());
            ext_rsp_ready = 1'($urandom_range(0, 1));
            #1;
            n_tests++; if (ext_req_ready !== 1'b0) begin n_fail++; $display("FAIL tied_req_ready[%0d]: got %b want 0", c, ext_req_ready); end
            tick();
            n_tests++; if (ext_rsp_valid !== 1'b0 || ext_rsp_rdata !== 32'h0 || ext_rsp_err !== 1'b0) begin
                n_fail++; $display("FAIL tied_rsp[%0d]: got %b/%h/%b want 0/0/0", c, ext_rsp_valid, ext_rsp_rdata, ext_rsp_err);
            end
        end
        ext_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        ext_rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            core_op(1'b1, 1'b0, BASE + 32'(i * 4), 4'h0, 32'h0);
            n_tests++; if (core_rd_data !== exp_rd) begin n_fail++; $display("FAIL tied_no_write[%0d]: got %h want %h", i, core_rd_data, exp_rd); end
        end
    endtask
`endif

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Test sequence and final report
    initial begin
        test_reset();
        test_preload();
        test_core_directed();
        test_core_oor();
        test_core_random();
`ifdef SIICPU_SPM_EXT_PORT_EN
        test_ext_priority();
        test_ext_write_oor();
        test_ext_random();
        test_ext_reset_mid_rsp();
`else
        test_ext_tied_off();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
